// File: rtl/uart_debug_ctrl.sv
// ---------------------------------------------------------------------------
// uart_debug_ctrl
//
// Debug controller sitting between the board UART and the MIPS core.
// After reset it assembles received UART bytes into instruction words and
// writes them into instruction memory until the halt word has been written
// (or the memory is full). It then accepts command bytes to free-run or
// single-step the core, and reports a status word back over the UART after
// each step and when the core halts.
//
// Ports:
//   i_clock        system clock (all state changes on its rising edge)
//   i_reset        synchronous, active-high reset
//   i_rx_done      one-cycle pulse, i_rx_data holds a received byte
//   i_rx_data      received byte
//   i_tx_available UART transmitter idle
//   o_tx_signal    one-cycle pulse to start transmitting o_tx_result
//   o_tx_result    byte to transmit (held until the next byte)
//   o_imem_we      instruction memory write strobe
//   o_imem_addr    instruction memory write address
//   o_imem_data    instruction memory write data
//   o_cpu_enable   core clock-enable
//   i_cpu_halt     core has retired the halt word (level)
//   i_status       word reported back to the host (PC or WB result)
//   o_state        current FSM state, for debug
//
// Optional feature (macro UART_DEBUG_TIMEOUT_EN):
//   When defined, a partial word held in LOAD is discarded if no further
//   byte arrives within TIMEOUT_CYCLES cycles. When undefined, a partial
//   word waits indefinitely.
// ---------------------------------------------------------------------------
module uart_debug_ctrl #(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         DATA_WIDTH_UART = 8,
    parameter int                         IMEM_DEPTH      = 64,
    parameter int                         MSB_FIRST       = 0,
    parameter logic [DATA_WIDTH-1:0]      HALT_WORD       = 32'hFC000000,
    parameter logic [DATA_WIDTH_UART-1:0] CMD_STEP_MODE   = 8'hFF,
    parameter logic [DATA_WIDTH_UART-1:0] CMD_STEP        = 8'hAA,
    parameter logic [DATA_WIDTH_UART-1:0] CMD_RUN         = 8'hCC
`ifdef UART_DEBUG_TIMEOUT_EN
    ,
    parameter int                         TIMEOUT_CYCLES  = 200000
`endif
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_rx_done,
    input  logic [DATA_WIDTH_UART-1:0]    i_rx_data,
    input  logic                          i_tx_available,
    output logic                          o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0]    o_tx_result,
    output logic                          o_imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0]         o_imem_data,
    output logic                          o_cpu_enable,
    input  logic                          i_cpu_halt,
    input  logic [DATA_WIDTH-1:0]         i_status,
    output logic [2:0]                    o_state
);

    localparam int AW        = $clog2(IMEM_DEPTH);
    localparam int NUM_BYTES = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int CW        = $clog2(NUM_BYTES + 1);

    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

`ifdef UART_DEBUG_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        CMD       = 3'd1,
        RUN       = 3'd2,
        STEP_EXEC = 3'd3,
        SEND      = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TX_WAIT_IDLE = 2'd0,
        TX_WAIT_FALL = 2'd1,
        TX_WAIT_RISE = 2'd2
    } tx_phase_t;

    state_t                     state_q,      state_d;
    logic [CW-1:0]              byte_cnt_q,   byte_cnt_d;
    logic [DATA_WIDTH-1:0]      word_q,       word_d;
    logic [AW-1:0]              addr_q,       addr_d;
    logic                       we_q,         we_d;
    logic [DATA_WIDTH-1:0]      wdata_q,      wdata_d;
    logic                       step_mode_q,  step_mode_d;
    logic                       done_flag_q,  done_flag_d;
    logic                       step_phase_q, step_phase_d;
    logic [DATA_WIDTH-1:0]      status_q,     status_d;
    logic [CW-1:0]              tx_cnt_q,     tx_cnt_d;
    tx_phase_t                  tx_phase_q,   tx_phase_d;
    logic                       tx_signal_q,  tx_signal_d;
    logic [DATA_WIDTH_UART-1:0] tx_result_q,  tx_result_d;
`ifdef UART_DEBUG_TIMEOUT_EN
    logic [TW-1:0]              tmo_q,        tmo_d;
`endif

    logic [DATA_WIDTH_UART-1:0] tx_byte;

    // Insert a new byte into the partial word. Shifting (rather than
    // indexing by the byte counter) leaves the first byte received at the
    // bottom for LSB-first order, or at the top for MSB-first order, once
    // the word is complete.
    function automatic logic [DATA_WIDTH-1:0] assemble(
        input logic [DATA_WIDTH-1:0]      w,
        input logic [DATA_WIDTH_UART-1:0] b
    );
        if (MSB_FIRST != 0)
            return (w << DATA_WIDTH_UART) | DATA_WIDTH'(b);
        else
            return (w >> DATA_WIDTH_UART) | (DATA_WIDTH'(b) << (DATA_WIDTH - DATA_WIDTH_UART));
    endfunction

    // The status register is shifted after every byte, so the byte to send
    // always sits at the same end of it.
    assign tx_byte = (MSB_FIRST != 0) ? status_q[DATA_WIDTH-1 -: DATA_WIDTH_UART]
                                      : status_q[DATA_WIDTH_UART-1:0];

    assign o_state      = state_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = wdata_q;
    assign o_tx_signal  = tx_signal_q;
    assign o_tx_result  = tx_result_q;
    // A step is a single enabled cycle followed by a settle cycle in which
    // the core's post-step status is captured.
    assign o_cpu_enable = (state_q == RUN) || ((state_q == STEP_EXEC) && !step_phase_q);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= LOAD;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            step_mode_q  <= 1'b0;
            done_flag_q  <= 1'b0;
            step_phase_q <= 1'b0;
            status_q     <= '0;
            tx_cnt_q     <= '0;
            tx_phase_q   <= TX_WAIT_IDLE;
            tx_signal_q  <= 1'b0;
            tx_result_q  <= '0;
`ifdef UART_DEBUG_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            step_mode_q  <= step_mode_d;
            done_flag_q  <= done_flag_d;
            step_phase_q <= step_phase_d;
            status_q     <= status_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_phase_q   <= tx_phase_d;
            tx_signal_q  <= tx_signal_d;
            tx_result_q  <= tx_result_d;
`ifdef UART_DEBUG_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        step_mode_d  = step_mode_q;
        done_flag_d  = done_flag_q;
        step_phase_d = step_phase_q;
        status_d     = status_q;
        tx_cnt_d     = tx_cnt_q;
        tx_phase_d   = tx_phase_q;
        tx_signal_d  = 1'b0;
        tx_result_d  = tx_result_q;
`ifdef UART_DEBUG_TIMEOUT_EN
        tmo_d        = '0;
`endif

        case (state_q)
            LOAD: begin
`ifdef UART_DEBUG_TIMEOUT_EN
                // Idle time is only counted while a partial word is held;
                // any received byte restarts the count via the default.
                if ((byte_cnt_q != '0) && !i_rx_done) begin
                    if (tmo_q == TMO_LAST) begin
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
                if (i_rx_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        we_d       = 1'b1;
                        wdata_d    = assemble(word_q, i_rx_data);
                        word_d     = '0;
                        byte_cnt_d = '0;
                    end else begin
                        word_d     = assemble(word_q, i_rx_data);
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                // The write cycle is one cycle after the last byte; the
                // address advances and the exit decision is made as it ends.
                // The last memory slot does not wrap back to zero.
                if (we_q) begin
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if ((wdata_q == HALT_WORD) || (addr_q == LAST_ADDR)) begin
                        state_d    = CMD;
                        byte_cnt_d = '0;
                        word_d     = '0;
                        we_d       = 1'b0;
                    end
                end
            end

            CMD: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_STEP_MODE) begin
                        step_mode_d = 1'b1;
                    end else if (i_rx_data == CMD_STEP) begin
                        if (step_mode_q) begin
                            state_d      = STEP_EXEC;
                            step_phase_d = 1'b0;
                        end
                    end else if (i_rx_data == CMD_RUN) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (i_cpu_halt) begin
                    status_d    = i_status;
                    done_flag_d = 1'b1;
                    state_d     = SEND;
                    tx_cnt_d    = '0;
                    tx_phase_d  = TX_WAIT_IDLE;
                end
            end

            STEP_EXEC: begin
                if (i_cpu_halt) begin
                    done_flag_d = 1'b1;
                end
                if (!step_phase_q) begin
                    step_phase_d = 1'b1;
                end else begin
                    step_phase_d = 1'b0;
                    status_d     = i_status;
                    state_d      = SEND;
                    tx_cnt_d     = '0;
                    tx_phase_d   = TX_WAIT_IDLE;
                end
            end

            SEND: begin
                // Each byte is a full handshake: pulse while the transmitter
                // is idle, then see it go busy and return to idle before the
                // next byte is offered.
                case (tx_phase_q)
                    TX_WAIT_IDLE: begin
                        if (i_tx_available) begin
                            tx_signal_d = 1'b1;
                            tx_result_d = tx_byte;
                            tx_phase_d  = TX_WAIT_FALL;
                        end
                    end
                    TX_WAIT_FALL: begin
                        if (!i_tx_available) begin
                            tx_phase_d = TX_WAIT_RISE;
                        end
                    end
                    TX_WAIT_RISE: begin
                        if (i_tx_available) begin
                            status_d   = (MSB_FIRST != 0) ? (status_q << DATA_WIDTH_UART)
                                                          : (status_q >> DATA_WIDTH_UART);
                            tx_phase_d = TX_WAIT_IDLE;
                            if (tx_cnt_q == LAST_BYTE) begin
                                tx_cnt_d = '0;
                                state_d  = done_flag_q ? DONE : CMD;
                            end else begin
                                tx_cnt_d = tx_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_phase_d = TX_WAIT_IDLE;
                    end
                endcase
            end

            DONE: begin
                // Terminal until reset.
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_debug_ctrl
//
// Directed testbench for uart_debug_ctrl. Stimulus pushes expected memory
// writes and transmitted bytes into queues; a monitor process pops and
// compares them whenever the DUT strobes o_imem_we or o_tx_signal. A simple
// transmitter model drops i_tx_available for a few cycles after each pulse.
// ---------------------------------------------------------------------------
module tb_uart_debug_ctrl;

    localparam int AW = 6;
`ifdef UART_DEBUG_TIMEOUT_EN
    localparam int TMO = 40;
`endif

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_rx_done;
    logic [7:0]    i_rx_data;
    logic          tx_avail;
    logic          o_tx_signal;
    logic [7:0]    o_tx_result;
    logic          o_imem_we;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_data;
    logic          o_cpu_enable;
    logic          i_cpu_halt;
    logic [31:0]   i_status;
    logic [2:0]    o_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_total     = 0;
    int en_snap;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [7:0]    exp_tx_q[$];

    always #5 i_clock = ~i_clock;

    uart_debug_ctrl #(
        .DATA_WIDTH      (32),
        .DATA_WIDTH_UART (8),
        .IMEM_DEPTH      (64),
        .MSB_FIRST       (0)
`ifdef UART_DEBUG_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES  (TMO)
`endif
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx_done      (i_rx_done),
        .i_rx_data      (i_rx_data),
        .i_tx_available (tx_avail),
        .o_tx_signal    (o_tx_signal),
        .o_tx_result    (o_tx_result),
        .o_imem_we      (o_imem_we),
        .o_imem_addr    (o_imem_addr),
        .o_imem_data    (o_imem_data),
        .o_cpu_enable   (o_cpu_enable),
        .i_cpu_halt     (i_cpu_halt),
        .i_status       (i_status),
        .o_state        (o_state)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Send one received byte as a single-cycle i_rx_done pulse plus a gap.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge i_clock); #1;
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge i_clock); #1;
        i_rx_done = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
    endtask

    task automatic sendWord(input logic [AW-1:0] a, input logic [31:0] w);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(w);
        for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8]);
    endtask

    task automatic applyReset();
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic waitState(input logic [2:0] s, input int max_cycles, input string name);
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge i_clock);
            if (o_state == s) break;
        end
        checkOutput(name, 64'(o_state), 64'(s));
    endtask

    // Scoreboard monitor: compares each strobed write / TX byte with the
    // oldest expectation; also counts enabled core cycles.
    task automatic monitorLoop();
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic [7:0]    et;
        forever begin
            @(negedge i_clock);
            if (o_cpu_enable) en_total++;
            if (o_imem_we) begin
                if (exp_addr_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write", o_imem_addr, o_imem_data);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    checkOutput("imem_addr", 64'(o_imem_addr), 64'(ea));
                    checkOutput("imem_data", 64'(o_imem_data), 64'(ed));
                end
            end
            if (o_tx_signal) begin
                if (exp_tx_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_tx: got byte %h, expected no transmission", o_tx_result);
                end else begin
                    et = exp_tx_q.pop_front();
                    checkOutput("tx_byte", 64'(o_tx_result), 64'(et));
                end
            end
        end
    endtask

    task automatic uartModel();
        forever begin
            @(negedge i_clock);
            if (o_tx_signal) begin
                tx_avail = 1'b0;
                repeat (3) @(negedge i_clock);
                tx_avail = 1'b1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset    = 1'b1;
        i_rx_done  = 1'b0;
        i_rx_data  = '0;
        i_cpu_halt = 1'b0;
        i_status   = '0;
        tx_avail   = 1'b1;
        fork
            monitorLoop();
            uartModel();
        join_none

        // Reset state
        applyReset();
        @(negedge i_clock);
        checkOutput("reset_state",     64'(o_state),      64'd0);
        checkOutput("reset_imem_we",   64'(o_imem_we),    64'd0);
        checkOutput("reset_imem_addr", 64'(o_imem_addr),  64'd0);
        checkOutput("reset_imem_data", 64'(o_imem_data),  64'd0);
        checkOutput("reset_cpu_en",    64'(o_cpu_enable), 64'd0);
        checkOutput("reset_tx_signal", 64'(o_tx_signal),  64'd0);
        checkOutput("reset_tx_result", 64'(o_tx_result),  64'd0);

`ifdef UART_DEBUG_TIMEOUT_EN
        // Partial word abandoned by a long gap, then a full word.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (TMO + 10) @(posedge i_clock);
        exp_addr_q.push_back(6'd0);
        exp_data_q.push_back(32'h04030201);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        checkOutput("timeout_addr_after", 64'(o_imem_addr), 64'd1);
        applyReset();
`endif

        // Reset in the middle of a word discards the partial bytes.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyReset();
        exp_addr_q.push_back(6'd0);
        exp_data_q.push_back(32'hAC410008);
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        applyStimulus(8'h41);
        applyStimulus(8'hAC);
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        checkOutput("first_word_addr_after", 64'(o_imem_addr), 64'd1);
        checkOutput("first_word_state",      64'(o_state),     64'd0);

        // Fill addresses 1..29, halt word at 30.
        for (int i = 1; i < 30; i++) begin
            sendWord(AW'(i), {8'(i), 8'hA5, 8'h5A, 8'(3 * i)});
        end
        sendWord(6'd30, 32'hFC000000);
        waitState(3'd1, 20, "load_to_cmd");
        checkOutput("addr_after_halt", 64'(o_imem_addr), 64'd31);
        applyStimulus(8'h12);
        repeat (5) @(posedge i_clock);
        @(negedge i_clock);
        checkOutput("cmd_ignores_byte", 64'(o_state), 64'd1);

        // Step without step mode is ignored.
        en_snap = en_total;
        applyStimulus(8'hAA);
        repeat (20) @(posedge i_clock);
        @(negedge i_clock);
        checkOutput("step_no_mode_en", 64'(en_total - en_snap), 64'd0);
        checkOutput("step_no_mode_state", 64'(o_state), 64'd1);

        // Step mode then one step reporting status 4 (LSB first).
        i_status = 32'h00000004;
        exp_tx_q.push_back(8'h04);
        exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(8'h00);
        en_snap = en_total;
        applyStimulus(8'hFF);
        @(negedge i_clock);
        checkOutput("step_mode_state", 64'(o_state), 64'd1);
        applyStimulus(8'hAA);
        waitState(3'd4, 20, "step1_send");
        waitState(3'd1, 200, "step1_back_cmd");
        checkOutput("step1_en_cycles", 64'(en_total - en_snap), 64'd1);

        // Second step, different status to expose byte order.
        i_status = 32'h12345678;
        exp_tx_q.push_back(8'h78);
        exp_tx_q.push_back(8'h56);
        exp_tx_q.push_back(8'h34);
        exp_tx_q.push_back(8'h12);
        en_snap = en_total;
        applyStimulus(8'hAA);
        waitState(3'd4, 20, "step2_send");
        waitState(3'd1, 200, "step2_back_cmd");
        checkOutput("step2_en_cycles", 64'(en_total - en_snap), 64'd1);

        // Free-run for 50 cycles, then halt.
        i_status = 32'hDEADBEEF;
        exp_tx_q.push_back(8'hEF);
        exp_tx_q.push_back(8'hBE);
        exp_tx_q.push_back(8'hAD);
        exp_tx_q.push_back(8'hDE);
        en_snap = en_total;
        @(posedge i_clock); #1;
        i_rx_done = 1'b1;
        i_rx_data = 8'hCC;
        @(posedge i_clock); #1;
        i_rx_done = 1'b0;
        repeat (49) @(posedge i_clock);
        #1;
        i_cpu_halt = 1'b1;
        waitState(3'd5, 200, "run_to_done");
        checkOutput("run_en_cycles", 64'(en_total - en_snap), 64'd50);
        applyStimulus(8'hAA);
        repeat (10) @(posedge i_clock);
        @(negedge i_clock);
        checkOutput("done_state_kept", 64'(o_state),      64'd5);
        checkOutput("done_cpu_en",     64'(o_cpu_enable), 64'd0);
        checkOutput("done_en_cycles",  64'(en_total - en_snap), 64'd50);

        repeat (5) @(posedge i_clock);
        checkOutput("writes_pending", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("tx_pending",     64'(exp_tx_q.size()),   64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
